// File: rtl/bg_tile_pkg.sv
// Shared constants and state encoding for the background tile-RAM write scheduler.
package bg_tile_pkg;

  localparam int TILE_COLS_DEF  = 40;
  localparam int TILE_ROWS_DEF  = 30;
  localparam int TILE_COUNT_DEF = TILE_COLS_DEF * TILE_ROWS_DEF;
  localparam int DROP_W         = 8;

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } wr_state_e;

endpackage

// File: rtl/bg_rr_arbiter.sv
// One-hot grant selection over N_CH requesters.
// BG_WRITE_ROUND_ROBIN_EN selects rotating priority; otherwise the lowest index wins.
module bg_rr_arbiter #(
  parameter int N_CH = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] req,
  input  logic            advance,
  output logic [N_CH-1:0] grant
);

`ifdef BG_WRITE_ROUND_ROBIN_EN
  localparam int PTR_W = $clog2(N_CH);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] gnt_idx;
  logic             found;

  // Two passes: first the channels at or above the pointer, then wrap to the bottom.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (!found && req[i] && (PTR_W'(i) >= ptr)) begin
        grant[i] = 1'b1;
        gnt_idx  = PTR_W'(i);
        found    = 1'b1;
      end
    end
    for (int i = 0; i < N_CH; i++) begin
      if (!found && req[i]) begin
        grant[i] = 1'b1;
        gnt_idx  = PTR_W'(i);
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= (gnt_idx == PTR_W'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end
`else
  logic found;
  logic unused_ok;

  assign unused_ok = ^{clk, reset, advance};

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (!found && req[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/bg_tile_writer.sv
// Background tile-RAM write scheduler: arbitrated client writes plus a full-screen clear sweep.
// Arbitration mode is chosen by BG_WRITE_ROUND_ROBIN_EN (fixed priority when undefined).
//
// state | meaning
// ARB   | grant one client request per cycle, drop out-of-range addresses
// CLEAR | write CLEAR_DATA to every tile, one per cycle, no client grants
module bg_tile_writer
  import bg_tile_pkg::*;
#(
  parameter int                N_CH       = 5,
  parameter int                ADDR_W     = 16,
  parameter int                DATA_W     = 32,
  parameter int                TILE_COLS  = TILE_COLS_DEF,
  parameter int                TILE_ROWS  = TILE_ROWS_DEF,
  parameter logic [DATA_W-1:0] CLEAR_DATA = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_CH-1:0]        req,
  input  logic [N_CH*ADDR_W-1:0] addr,
  input  logic [N_CH*DATA_W-1:0] data,
  output logic [N_CH-1:0]        ack,
  input  logic                   clear_start,
  output logic                   clear_busy,
  output logic                   bg_wea,
  output logic [ADDR_W-1:0]      bg_ram_addr,
  output logic [DATA_W-1:0]      bg_ram_data,
  output logic [DROP_W-1:0]      drop_count
);

  localparam int                TILE_COUNT = TILE_COLS * TILE_ROWS;
  localparam logic [ADDR_W:0]   TILE_LIMIT = (ADDR_W + 1)'(TILE_COUNT);
  localparam logic [ADDR_W-1:0] CLR_LAST   = ADDR_W'(TILE_COUNT - 1);

  wr_state_e         state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
  logic [N_CH-1:0]   grant;
  logic              advance;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              in_range;

  logic [N_CH-1:0]   ack_nxt;
  logic              busy_nxt;
  logic              wea_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic [DROP_W-1:0] drop_nxt;

  bg_rr_arbiter #(
    .N_CH (N_CH)
  ) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .advance (advance),
    .grant   (grant)
  );

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant[i]) begin
        sel_addr = addr[i*ADDR_W +: ADDR_W];
        sel_data = data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign in_range = ({1'b0, sel_addr} < TILE_LIMIT);

  // Address/data hold their previous values when nothing is written.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    ack_nxt     = '0;
    busy_nxt    = 1'b0;
    wea_nxt     = 1'b0;
    addr_nxt    = bg_ram_addr;
    data_nxt    = bg_ram_data;
    drop_nxt    = drop_count;
    advance     = 1'b0;
    case (state)
      ARB: begin
        if (clear_start) begin
          state_nxt   = CLEAR;
          clr_cnt_nxt = '0;
        end else if (|grant) begin
          advance = 1'b1;
          ack_nxt = grant;
          if (in_range) begin
            wea_nxt  = 1'b1;
            addr_nxt = sel_addr;
            data_nxt = sel_data;
          end else if (drop_count != {DROP_W{1'b1}}) begin
            drop_nxt = drop_count + 1'b1;
          end
        end
      end
      CLEAR: begin
        busy_nxt = 1'b1;
        wea_nxt  = 1'b1;
        addr_nxt = clr_cnt;
        data_nxt = CLEAR_DATA;
        // A restart still issues the current write, then begins again from tile 0.
        if (clear_start) begin
          clr_cnt_nxt = '0;
        end else if (clr_cnt == CLR_LAST) begin
          clr_cnt_nxt = '0;
          state_nxt   = ARB;
        end else begin
          clr_cnt_nxt = clr_cnt + 1'b1;
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ARB;
      clr_cnt     <= '0;
      ack         <= '0;
      clear_busy  <= 1'b0;
      bg_wea      <= 1'b0;
      bg_ram_addr <= '0;
      bg_ram_data <= '0;
      drop_count  <= '0;
    end else begin
      state       <= state_nxt;
      clr_cnt     <= clr_cnt_nxt;
      ack         <= ack_nxt;
      clear_busy  <= busy_nxt;
      bg_wea      <= wea_nxt;
      bg_ram_addr <= addr_nxt;
      bg_ram_data <= data_nxt;
      drop_count  <= drop_nxt;
    end
  end

endmodule

// File: tb/tb_bg_tile_writer.sv
// Directed bench for bg_tile_writer with hand-computed expectations.
module tb_bg_tile_writer;
  localparam int N_CH   = 5;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  logic                   clk;
  logic                   reset;
  logic [N_CH-1:0]        req;
  logic [N_CH*ADDR_W-1:0] addr;
  logic [N_CH*DATA_W-1:0] data;
  logic [N_CH-1:0]        ack;
  logic                   clear_start;
  logic                   clear_busy;
  logic                   bg_wea;
  logic [ADDR_W-1:0]      bg_ram_addr;
  logic [DATA_W-1:0]      bg_ram_data;
  logic [7:0]             drop_count;

  int errors = 0;
  int checks = 0;

  bg_tile_writer #(
    .N_CH   (N_CH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .addr        (addr),
    .data        (data),
    .ack         (ack),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .bg_wea      (bg_wea),
    .bg_ram_addr (bg_ram_addr),
    .bg_ram_data (bg_ram_data),
    .drop_count  (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    addr[ch*ADDR_W +: ADDR_W] = a;
    data[ch*DATA_W +: DATA_W] = d;
  endtask

  function automatic logic [63:0] all_outs();
    return {1'b0, ack, bg_wea, clear_busy, bg_ram_addr, bg_ram_data, drop_count};
  endfunction

  int n;
  int bad;
  int exp_addr;

  initial begin
    reset       = 1'b0;
    req         = '0;
    addr        = '0;
    data        = '0;
    clear_start = 1'b0;
    tick();
    tick();
    chk("in_reset", all_outs(), 64'd0);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_after_reset", all_outs(), 64'd0);
    end

    // all channels held continuously
    for (int i = 0; i < N_CH; i++) set_ch(i, ADDR_W'(i * 10), DATA_W'(32'hA0 + i));
    req = '1;
    for (int k = 0; k < 6; k++) begin
      tick();
`ifdef BG_WRITE_ROUND_ROBIN_EN
      chk("rr_ack", 64'(ack), 64'(5'b00001 << (k % N_CH)));
      chk("rr_addr", 64'(bg_ram_addr), 64'((k % N_CH) * 10));
`else
      chk("fixed_ack", 64'(ack), 64'b00001);
      chk("fixed_addr", 64'(bg_ram_addr), 64'd0);
`endif
      chk("all_wea", 64'(bg_wea), 64'd1);
    end
    req = '0;
    tick();
    chk("all_release_ack", 64'(ack), 64'd0);

    // single request on channel 2
    set_ch(2, 16'd85, 32'h1234);
    req = 5'b00100;
    tick();
    req = '0;
    chk("ch2_ack", 64'(ack), 64'b00100);
    chk("ch2_wea", 64'(bg_wea), 64'd1);
    chk("ch2_addr", 64'(bg_ram_addr), 64'd85);
    chk("ch2_data", 64'(bg_ram_data), 64'h1234);
    tick();
    chk("ch2_one_pulse", {ack, bg_wea}, 64'd0);
    chk("ch2_hold", {bg_ram_addr, bg_ram_data}, {16'd85, 32'h1234});

    // highest in-range address is written
    set_ch(0, 16'd1199, 32'hBEEF);
    req = 5'b00001;
    tick();
    req = '0;
    chk("edge_1199", {ack, bg_wea, bg_ram_addr, bg_ram_data}, {5'b00001, 1'b1, 16'd1199, 32'hBEEF});

    // out-of-range requests are acked, not written, and counted
    set_ch(1, 16'd1200, 32'hDEAD);
    req = 5'b00010;
    tick();
    chk("drop_first", {ack, bg_wea, drop_count}, {5'b00010, 1'b0, 8'd1});
    chk("drop_no_write", {bg_ram_addr, bg_ram_data}, {16'd1199, 32'hBEEF});
    for (int i = 1; i < 300; i++) tick();
    req = '0;
    chk("drop_saturate", 64'(drop_count), 64'd255);
    tick();
    chk("drop_idle", {ack, bg_wea, drop_count}, {5'b0, 1'b0, 8'd255});

    // clear sweep wins over a held request
    set_ch(3, 16'd7, 32'h77);
    req = 5'b01000;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    chk("clr_start_edge", {ack, bg_wea, clear_busy}, 64'd0);
    tick();
    n = 0;
    bad = 0;
    while (clear_busy && n < 3000) begin
      if (!(bg_wea && ack == '0 && bg_ram_addr == ADDR_W'(n) && bg_ram_data == '0)) bad++;
      n++;
      tick();
    end
    chk("clr_len", 64'(n), 64'd1200);
    chk("clr_bad_cycles", 64'(bad), 64'd0);
    chk("clr_then_ack", {ack, bg_wea, clear_busy, bg_ram_addr, bg_ram_data},
        {5'b01000, 1'b1, 1'b0, 16'd7, 32'h77});
    req = '0;
    tick();

    // restart the sweep when tile 600 is being written
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    chk("restart_pre_busy", 64'(clear_busy), 64'd0);
    tick();
    n = 0;
    bad = 0;
    while (clear_busy && n < 4000) begin
      exp_addr = (n <= 600) ? n : n - 601;
      if (!(bg_wea && ack == '0 && bg_ram_addr == ADDR_W'(exp_addr))) bad++;
      n++;
      clear_start = (n == 600);
      tick();
    end
    clear_start = 1'b0;
    chk("restart_len", 64'(n), 64'd1801);
    chk("restart_bad_cycles", 64'(bad), 64'd0);

    // async reset in the middle of a sweep
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    tick();
    for (int i = 0; i < 300; i++) tick();
    chk("pre_reset_addr", {clear_busy, bg_wea, bg_ram_addr}, {1'b1, 1'b1, 16'd300});
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset", all_outs(), 64'd0);
    #3;
    reset = 1'b1;
    tick();
    chk("post_reset_idle", {clear_busy, bg_wea, ack}, 64'd0);
    set_ch(4, 16'd5, 32'h55);
    req = 5'b10000;
    tick();
    req = '0;
    chk("post_reset_arb", {ack, bg_wea, clear_busy, bg_ram_addr, bg_ram_data},
        {5'b10000, 1'b1, 1'b0, 16'd5, 32'h55});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bg_tile_writer.md
# bg_tile_writer

Parametrised background tile-RAM write scheduler that replaces fixed time-slot multiplexing of tile writers (pipes, score, coin, text) with a request/acknowledge arbiter over N_CH client channels. It also provides a built-in full-screen clear sweep. It sits between the game-logic producers and the background RAM write port (bg_wea / bg_ram_addr / bg_ram_data). It issues at most one tile write per clock.

## Interface
- N_CH, 5, number of client write channels (≥2)
- ADDR_W, 16, tile-RAM address width
- DATA_W, 32, tile-RAM data width
- TILE_COLS, 40, tiles per row
- TILE_ROWS, 30, tile rows; TILE_COUNT = TILE_COLS*TILE_ROWS
- CLEAR_DATA, 0, word written by the clear sweep

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req  in  N_CH  per-channel write request, held until ack
- addr  in  N_CH*ADDR_W  per-channel tile address, channel i at [i*ADDR_W +: ADDR_W]
- data  in  N_CH*DATA_W  per-channel tile word, same packing
- ack  out  N_CH  one-cycle grant pulse, one-hot or zero
- clear_start  in  1  pulse: start/restart full clear sweep
- clear_busy  out  1  high while sweep in progress
- bg_wea  out  1  tile-RAM write enable
- bg_ram_addr  out  ADDR_W  tile-RAM address
- bg_ram_data  out  DATA_W  tile-RAM data
- drop_count  out  8  saturating count of out-of-range requests dropped

## Operation
- States: ARB, CLEAR. Reset → ARB.
- Reset values: ack=0, clear_busy=0, bg_wea=0, bg_ram_addr=0, bg_ram_data=0, drop_count=0, rr pointer=0, clear counter=0.
- ARB: each cycle, select one asserted req.
  - If the selected addr < TILE_COUNT: register ack[i]=1, bg_wea=1, bg_ram_addr=addr_i, bg_ram_data=data_i.
  - If the selected addr ≥ TILE_COUNT: ack[i]=1, bg_wea=0, drop_count+1, saturating at 255.
  - No req: ack=0, bg_wea=0. Address and data hold their last values.
- Selection: see Configuration.
- clear_start (any state) → CLEAR next edge. Counter=0, clear_busy=1.
- CLEAR: each cycle, write bg_wea=1, addr=counter, data=CLEAR_DATA, counter+1. After the write at TILE_COUNT-1, return to ARB and set clear_busy=0.
  - No acks during CLEAR. Requests stay pending.
  - clear_start during CLEAR restarts the counter at 0.
- Simultaneous clear_start and pending req in ARB: clear wins. No ack that cycle.
- Handshake: the client keeps req/addr/data stable until it sees ack. It may deassert or change them in the cycle after ack. A req still high after ack is a new request.
- Asynchronous reset mid-sweep or mid-grant: all outputs go immediately to their reset values. The sweep is abandoned.

## Timing
- All outputs are registered.
- Request present at edge k → ack and write visible after edge k, during cycle k+1. Latency is 1.
- Throughput is 1 write/cycle. A sweep occupies exactly TILE_COUNT cycles (1200 by default).
- clear_start at edge k: the first clear write (addr 0) is visible after edge k+1. clear_busy rises at the same point and falls after the edge that issues the write at TILE_COUNT-1.
- Round-robin worst-case wait for a continuously requesting channel: N_CH-1 grants, excluding clear.

## Configuration
- BG_WRITE_ROUND_ROBIN_EN defined:
  - Round-robin arbitration. Search starts at rr pointer.
  - After a grant to channel i, pointer = (i+1) mod N_CH. Drops also advance the pointer.
- Undefined: fixed priority, lowest index wins. There is no pointer register.

## Structure
- Package bg_tile_pkg:
  - TILE_COLS/TILE_ROWS/TILE_COUNT defaults
  - state enum {ARB, CLEAR}
  - drop_count width constant
- Sub-module bg_rr_arbiter: N_CH-wide req in, one-hot grant out, with pointer update. Its priority mode is selected by the macro.
- Top level holds the FSM, clear counter, range check, output registers and drop counter.

## Test plan
- Reset release, no req → all outputs 0 and clear_busy=0 for 10 cycles.
- req[2] with addr=85, data=0x1234 → ack[2] and bg_wea=1 with addr 85 / data 0x1234 one cycle later, exactly one pulse.
- req all channels held (round-robin build) → grants in order 0,1,2,3,4,0…. Fixed-priority build → ack[0] every cycle.
- req[1] with addr=1200 → ack[1]=1, bg_wea=0, drop_count=1. Repeat 300× → drop_count=255.
- clear_start while req[3] held → 1200 consecutive writes of CLEAR_DATA, addr 0..1199. ack[3] first appears the cycle after clear_busy falls.
- clear_start again at sweep addr 600 → addr restarts at 0, total busy 601+1200 cycles. Assert reset at addr 300 → outputs 0 at once, ARB state after release.
